mcpu_core_ptw_arb: RTL

//  Shared page-table walker for ITLB and DTLB misses. Arbitrates round-robin between the
//  I-side and D-side requesters, walks the two-level page table through a single-outstanding

---
 rtl/mcpu_core_ptw_pkg.sv | 29 ++
 rtl/mcpu_core_rr_arb2.sv | 43 ++++
 rtl/mcpu_core_ptw_arb.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/mcpu_core_ptw_pkg.sv
// Shared definitions for the page-table walker: walk states, PTE field positions,
// requester side encodings and the entry-page extraction helper.
package mcpu_core_ptw_pkg;

   localparam int PAGE_BITS = 20;
   localparam int IDX_BITS  = 10;
   localparam int ADDR_BITS = PAGE_BITS + IDX_BITS;

   localparam int PTE_PAGE_HI = 31;
   localparam int PTE_PAGE_LO = 12;
   localparam int PTE_PRESENT = 0;

   localparam logic SIDE_I = 1'b0;
   localparam logic SIDE_D = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_L1_REQ,
      ST_L1_WAIT,
      ST_L2_REQ,
      ST_L2_WAIT,
      ST_DONE
   } ptw_state_e;

   function automatic logic [PAGE_BITS-1:0] pte_page(input logic [31:0] entry);
      return entry[PTE_PAGE_HI:PTE_PAGE_LO];
   endfunction

endpackage

// File: rtl/mcpu_core_rr_arb2.sv
// Two-way round-robin arbiter between the I-side and D-side requesters.
// A tie goes to the side that did not win last; the history only moves when the grant is used.
module mcpu_core_rr_arb2
   import mcpu_core_ptw_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic req_i,
   input  logic req_d,
   input  logic update,
   output logic gnt_valid,
   output logic gnt_side
);

   logic last_grant_q;
   logic last_grant_d;

   always_comb begin
      gnt_valid = req_i | req_d;
      if (req_i && req_d) begin
         gnt_side = ~last_grant_q;
      end else if (req_d) begin
         gnt_side = SIDE_D;
      end else begin
         gnt_side = SIDE_I;
      end

      last_grant_d = last_grant_q;
      if (update) begin
         last_grant_d = gnt_side;
      end
   end

   // Reset history to D so the I-side wins the first tie.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant_q <= SIDE_D;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end

endmodule

// File: rtl/mcpu_core_ptw_arb.sv
// Shared two-level page-table walker serving ITLB and DTLB misses through a single
// outstanding memory read; pipe_flush abandons an I-side walk without a response.
module mcpu_core_ptw_arb
   import mcpu_core_ptw_pkg::*;
(
   input  logic        clkrst_core_clk,
   input  logic        clkrst_core_rst,
   input  logic        itlb2ptw_valid,
   input  logic [19:0] itlb2ptw_virtpage,
   output logic        ptw2itlb_ready,
   output logic [19:0] ptw2itlb_physpage,
   output logic        ptw2itlb_pagefault,
   input  logic        dtlb2ptw_valid,
   input  logic [19:0] dtlb2ptw_virtpage,
   output logic        ptw2dtlb_ready,
   output logic [19:0] ptw2dtlb_physpage,
   output logic        ptw2dtlb_pagefault,
   input  logic [19:0] ptbr,
   input  logic        pipe_flush,
   output logic        ptw2mem_valid,
   output logic [29:0] ptw2mem_addr,
   input  logic        mem2ptw_ready,
   input  logic        mem2ptw_rvalid,
   input  logic [31:0] mem2ptw_rdata
);

   ptw_state_e  state_q, state_d;
   logic        side_q, side_d;
   logic [19:0] vpage_q, vpage_d;
   logic [19:0] ptbr_q, ptbr_d;
   logic [19:0] pde_page_q, pde_page_d;
   logic [19:0] physpage_q, physpage_d;
   logic        fault_q, fault_d;
   logic        abort_q, abort_d;

   logic gnt_valid;
   logic gnt_side;
   logic arb_update;
   logic flush_i;
   logic abort_now;
   logic resp_fire;
   logic unused_rdata;

   assign unused_rdata = ^mem2ptw_rdata[PTE_PAGE_LO-1:PTE_PRESENT+1];

   mcpu_core_rr_arb2 u_arb (
      .clk       (clkrst_core_clk),
      .rst       (clkrst_core_rst),
      .req_i     (itlb2ptw_valid & ~pipe_flush),
      .req_d     (dtlb2ptw_valid),
      .update    (arb_update),
      .gnt_valid (gnt_valid),
      .gnt_side  (gnt_side)
   );

   assign arb_update = (state_q == ST_IDLE) & gnt_valid;
   assign flush_i    = pipe_flush & (side_q == SIDE_I);
   assign abort_now  = abort_q | flush_i;

   assign ptw2mem_valid = (state_q == ST_L1_REQ) | (state_q == ST_L2_REQ);

   always_comb begin
      ptw2mem_addr = '0;
      if (state_q == ST_L1_REQ) begin
         ptw2mem_addr = {ptbr_q, vpage_q[19:10]};
      end else if (state_q == ST_L2_REQ) begin
         ptw2mem_addr = {pde_page_q, vpage_q[9:0]};
      end
   end

   // Walk sequencing; a flushed I-walk whose read is already accepted drains it before idling.
   always_comb begin
      state_d    = state_q;
      side_d     = side_q;
      vpage_d    = vpage_q;
      ptbr_d     = ptbr_q;
      pde_page_d = pde_page_q;
      physpage_d = physpage_q;
      fault_d    = fault_q;
      abort_d    = abort_q;

      case (state_q)
         ST_IDLE: begin
            abort_d = 1'b0;
            if (gnt_valid) begin
               state_d = ST_L1_REQ;
               side_d  = gnt_side;
               vpage_d = (gnt_side == SIDE_I) ? itlb2ptw_virtpage : dtlb2ptw_virtpage;
               ptbr_d  = ptbr;
            end
         end
         ST_L1_REQ, ST_L2_REQ: begin
            if (mem2ptw_ready) begin
               state_d = (state_q == ST_L1_REQ) ? ST_L1_WAIT : ST_L2_WAIT;
               abort_d = abort_now;
            end else if (flush_i) begin
               state_d = ST_IDLE;
               abort_d = 1'b0;
            end
         end
         ST_L1_WAIT: begin
            abort_d = abort_now;
            if (mem2ptw_rvalid) begin
               if (abort_now) begin
                  state_d = ST_IDLE;
                  abort_d = 1'b0;
               end else if (!mem2ptw_rdata[PTE_PRESENT]) begin
                  state_d    = ST_DONE;
                  fault_d    = 1'b1;
                  physpage_d = '0;
               end else begin
                  state_d    = ST_L2_REQ;
                  pde_page_d = pte_page(mem2ptw_rdata);
               end
            end
         end
         ST_L2_WAIT: begin
            abort_d = abort_now;
            if (mem2ptw_rvalid) begin
               if (abort_now) begin
                  state_d = ST_IDLE;
                  abort_d = 1'b0;
               end else begin
                  state_d    = ST_DONE;
                  fault_d    = ~mem2ptw_rdata[PTE_PRESENT];
                  physpage_d = mem2ptw_rdata[PTE_PRESENT] ? pte_page(mem2ptw_rdata) : '0;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            abort_d = 1'b0;
         end
         default: begin
            state_d = ST_IDLE;
            abort_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
      if (clkrst_core_rst) begin
         state_q    <= ST_IDLE;
         side_q     <= SIDE_I;
         vpage_q    <= '0;
         ptbr_q     <= '0;
         pde_page_q <= '0;
         physpage_q <= '0;
         fault_q    <= 1'b0;
         abort_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         side_q     <= side_d;
         vpage_q    <= vpage_d;
         ptbr_q     <= ptbr_d;
         pde_page_q <= pde_page_d;
         physpage_q <= physpage_d;
         fault_q    <= fault_d;
         abort_q    <= abort_d;
      end
   end

   // The response is shown only to the granted side; a flush in DONE swallows an I response.
   assign resp_fire          = (state_q == ST_DONE) & ~abort_q;
   assign ptw2itlb_ready     = resp_fire & (side_q == SIDE_I) & ~pipe_flush;
   assign ptw2dtlb_ready     = resp_fire & (side_q == SIDE_D);
   assign ptw2itlb_physpage  = ptw2itlb_ready ? physpage_q : '0;
   assign ptw2itlb_pagefault = ptw2itlb_ready & fault_q;
   assign ptw2dtlb_physpage  = ptw2dtlb_ready ? physpage_q : '0;
   assign ptw2dtlb_pagefault = ptw2dtlb_ready & fault_q;

endmodule
